// File: rtl/find_next_one_index_seq_if.sv
// Request/result handshake bundle for find_next_one_index_seq.
// The master drives requests and consumes results; the slave is the search block.
interface find_next_one_index_seq_if #(
   parameter int VECTOR_LENGTH    = 32,
   parameter int MAX_OUTPUT_WIDTH = 32
);
   logic                        request_valid_in;
   logic                        request_ready_out;
   logic [VECTOR_LENGTH-1:0]    vector_in;
   logic [MAX_OUTPUT_WIDTH-1:0] start_index_in;
   logic                        result_valid_out;
   logic                        result_ready_in;
   logic [MAX_OUTPUT_WIDTH-1:0] first_one_index_out;
   logic                        one_is_found_out;

   modport master (
      output request_valid_in, vector_in, start_index_in, result_ready_in,
      input  request_ready_out, result_valid_out, first_one_index_out, one_is_found_out
   );

   modport slave (
      input  request_valid_in, vector_in, start_index_in, result_ready_in,
      output request_ready_out, result_valid_out, first_one_index_out, one_is_found_out
   );
endinterface

// File: rtl/find_next_one_index_seq.sv
// Segmented first-one finder: scans SEGMENT_WIDTH bits per cycle from a start index.
// Define FIND_ONE_WRAP_EN for a circular search that wraps back below the start index.
module find_next_one_index_seq #(
   parameter int VECTOR_LENGTH    = 32,
   parameter int SEGMENT_WIDTH    = 8,
   parameter int MAX_OUTPUT_WIDTH = 32
) (
   input logic                      clk_in,
   input logic                      reset_in,
   find_next_one_index_seq_if.slave bus
);
   localparam int NUM_SEG = VECTOR_LENGTH / SEGMENT_WIDTH;
   localparam int IDX_W   = (VECTOR_LENGTH > 1) ? $clog2(VECTOR_LENGTH) : 1;
   localparam int SEG_W   = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;
   localparam int OFF_W   = (SEGMENT_WIDTH > 1) ? $clog2(SEGMENT_WIDTH) : 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SCAN = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]                             state_q;
   logic [NUM_SEG-1:0][SEGMENT_WIDTH-1:0]  vec_q;
   logic [SEG_W-1:0]                       seg_ptr_q;
   logic [SEG_W-1:0]                       start_seg_q;
   logic [OFF_W-1:0]                       start_off_q;
   logic [MAX_OUTPUT_WIDTH-1:0]            index_q;
   logic                                   found_q;
   logic                                   valid_q;
`ifdef FIND_ONE_WRAP_EN
   logic                                   wrapped_q;
`endif

   logic                      accept;
   logic [IDX_W-1:0]          start_idx;
   logic [SEG_W-1:0]          start_seg_d;
   logic [OFF_W-1:0]          start_off_d;
   logic [SEG_W-1:0]          next_ptr;
   logic                      first_visit;
   logic                      revisit;
   logic                      last_seg;
   logic [SEGMENT_WIDTH-1:0]  masked;
   logic                      hit;
   logic [OFF_W-1:0]          hit_off;
   logic [MAX_OUTPUT_WIDTH-1:0] hit_index;

   assign accept = bus.request_valid_in && (state_q == ST_IDLE);

   // Out-of-range start indices fold to 0.
   always_comb begin
      start_idx = '0;
      if (bus.start_index_in < MAX_OUTPUT_WIDTH'(VECTOR_LENGTH))
         start_idx = bus.start_index_in[IDX_W-1:0];
      start_seg_d = SEG_W'(32'(start_idx) / 32'(SEGMENT_WIDTH));
      start_off_d = OFF_W'(32'(start_idx) % 32'(SEGMENT_WIDTH));
   end

   assign next_ptr = (seg_ptr_q == SEG_W'(NUM_SEG - 1)) ? '0 : seg_ptr_q + 1'b1;

`ifdef FIND_ONE_WRAP_EN
   assign first_visit = (seg_ptr_q == start_seg_q) && !wrapped_q;
   assign revisit     = (seg_ptr_q == start_seg_q) && wrapped_q;
   // Aligned start ends one segment before the start; unaligned ends on the masked revisit.
   assign last_seg    = (start_off_q == '0) ? (next_ptr == start_seg_q) : revisit;
`else
   assign first_visit = (seg_ptr_q == start_seg_q);
   assign revisit     = 1'b0;
   assign last_seg    = (seg_ptr_q == SEG_W'(NUM_SEG - 1));
`endif

   // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      masked  = vec_q[seg_ptr_q];
      hit     = 1'b0;
      hit_off = '0;
      for (int i = 0; i < SEGMENT_WIDTH; i++) begin
         if (first_visit && (i < int'(start_off_q))) masked[i] = 1'b0;
         if (revisit && (i >= int'(start_off_q)))    masked[i] = 1'b0;
      end
      // NOTE: blocking assignments here are evaluated in order, so the last write (lowest bit) wins.
      for (int i = SEGMENT_WIDTH - 1; i >= 0; i--) begin
         if (masked[i]) begin
            hit     = 1'b1;
            hit_off = OFF_W'(i);
         end
      end
      hit_index = MAX_OUTPUT_WIDTH'(32'(seg_ptr_q) * 32'(SEGMENT_WIDTH) + 32'(hit_off));
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         state_q     <= ST_IDLE;
         seg_ptr_q   <= '0;
         start_seg_q <= '0;
         start_off_q <= '0;
         index_q     <= '0;
         found_q     <= 1'b0;
         valid_q     <= 1'b0;
`ifdef FIND_ONE_WRAP_EN
         wrapped_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  seg_ptr_q   <= start_seg_d;
                  start_seg_q <= start_seg_d;
                  start_off_q <= start_off_d;
`ifdef FIND_ONE_WRAP_EN
                  wrapped_q   <= 1'b0;
`endif
                  state_q     <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               if (hit) begin
                  index_q <= hit_index;
                  found_q <= 1'b1;
                  valid_q <= 1'b1;
                  state_q <= ST_DONE;
               end else if (last_seg) begin
                  index_q <= '0;
                  found_q <= 1'b0;
                  valid_q <= 1'b1;
                  state_q <= ST_DONE;
               end else begin
                  seg_ptr_q <= next_ptr;
`ifdef FIND_ONE_WRAP_EN
                  wrapped_q <= 1'b1;
`endif
               end
            end
            ST_DONE: begin
               if (bus.result_ready_in) begin
                  valid_q <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // NOTE: the vector store has no reset; it is always loaded on accept before it is read.
   always_ff @(posedge clk_in) begin
      if (accept) vec_q <= bus.vector_in;
   end

   assign bus.request_ready_out   = (state_q == ST_IDLE);
   assign bus.result_valid_out    = valid_q;
   assign bus.first_one_index_out = index_q;
   assign bus.one_is_found_out    = found_q;
endmodule

// File: tb/tb_find_next_one_index_seq.sv
// Directed bench for find_next_one_index_seq (VECTOR_LENGTH=32, SEGMENT_WIDTH=8).
// Expected values follow FIND_ONE_WRAP_EN when it is defined for the build.
module tb_find_next_one_index_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   find_next_one_index_seq_if #(.VECTOR_LENGTH(32), .MAX_OUTPUT_WIDTH(32)) bus ();

   find_next_one_index_seq #(
      .VECTOR_LENGTH(32), .SEGMENT_WIDTH(8), .MAX_OUTPUT_WIDTH(32)
   ) dut (
      .clk_in  (clk),
      .reset_in(rst),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Waits for result_valid, counting edges after the accepting edge.
   task automatic wait_result(output int lat);
      lat = 0;
      while (bus.result_valid_out !== 1'b1 && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic run_req(input string tag, input logic [31:0] vec, input logic [31:0] start,
                          input int exp_lat, input logic exp_found, input logic [31:0] exp_idx);
      int lat;
      @(negedge clk);
      check({tag, "_ready"}, 32'(bus.request_ready_out), 32'd1);
      bus.request_valid_in = 1'b1;
      bus.vector_in        = vec;
      bus.start_index_in   = start;
      @(posedge clk);
      #1;
      bus.request_valid_in = 1'b0;
      bus.vector_in        = $urandom;
      bus.start_index_in   = $urandom_range(0, 31);
      check({tag, "_busy"}, 32'(bus.request_ready_out), 32'd0);
      wait_result(lat);
      check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      check({tag, "_found"}, 32'(bus.one_is_found_out), 32'(exp_found));
      check({tag, "_idx"}, bus.first_one_index_out, exp_idx);
      @(posedge clk);
      #1;
      check({tag, "_drain"}, 32'(bus.result_valid_out), 32'd0);
   endtask

   initial begin
      int lat;
      bus.request_valid_in = 1'b0;
      bus.vector_in        = '0;
      bus.start_index_in   = '0;
      bus.result_ready_in  = 1'b1;
      #12;
      check("rst_ready", 32'(bus.request_ready_out), 32'd1);
      check("rst_valid", 32'(bus.result_valid_out), 32'd0);
      check("rst_idx", bus.first_one_index_out, 32'd0);
      check("rst_found", 32'(bus.one_is_found_out), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      run_req("zero_vec", 32'h0000_0000, 32'd0, 4, 1'b0, 32'd0);
      run_req("bit0", 32'h0000_0001, 32'd0, 1, 1'b1, 32'd0);
      run_req("bit31", 32'h8000_0000, 32'd0, 4, 1'b1, 32'd31);
      run_req("bit16_s16", 32'h0001_0000, 32'd16, 1, 1'b1, 32'd16);
      run_req("start_oob", 32'h0000_0001, 32'd40, 1, 1'b1, 32'd0);
      run_req("mask_s5", 32'h0000_0048, 32'd5, 1, 1'b1, 32'd6);
`ifdef FIND_ONE_WRAP_EN
      run_req("wrap_s20", 32'h0000_0010, 32'd20, 3, 1'b1, 32'd4);
      run_req("wrap_s7", 32'h0000_0048, 32'd7, 5, 1'b1, 32'd3);
      run_req("wrap_s1", 32'h0000_0001, 32'd1, 5, 1'b1, 32'd0);
`else
      run_req("nowrap_s20", 32'h0000_0010, 32'd20, 2, 1'b0, 32'd0);
      run_req("nowrap_s7", 32'h0000_0048, 32'd7, 4, 1'b0, 32'd0);
      run_req("nowrap_s1", 32'h0000_0001, 32'd1, 4, 1'b0, 32'd0);
`endif

      // Backpressure: result held while a second request waits.
      @(negedge clk);
      bus.result_ready_in  = 1'b0;
      bus.request_valid_in = 1'b1;
      bus.vector_in        = 32'h0000_0048;
      bus.start_index_in   = 32'd5;
      @(posedge clk);
      #1;
      bus.request_valid_in = 1'b0;
      wait_result(lat);
      check("bp_lat", 32'(lat), 32'd1);
      bus.request_valid_in = 1'b1;
      bus.vector_in        = 32'h0000_0400;
      bus.start_index_in   = 32'd0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_valid", 32'(bus.result_valid_out), 32'd1);
         check("bp_idx", bus.first_one_index_out, 32'd6);
         check("bp_found", 32'(bus.one_is_found_out), 32'd1);
         check("bp_ready", 32'(bus.request_ready_out), 32'd0);
      end
      bus.result_ready_in = 1'b1;
      @(posedge clk);
      #1;
      check("bp_hs_valid", 32'(bus.result_valid_out), 32'd0);
      check("bp_hs_ready", 32'(bus.request_ready_out), 32'd1);
      @(posedge clk);
      #1;
      check("bp_accept", 32'(bus.request_ready_out), 32'd0);
      bus.request_valid_in = 1'b0;
      wait_result(lat);
      check("bp2_lat", 32'(lat), 32'd2);
      check("bp2_idx", bus.first_one_index_out, 32'd10);
      check("bp2_found", 32'(bus.one_is_found_out), 32'd1);
      @(posedge clk);
      #1;

      // Asynchronous reset between edges while scanning.
      @(negedge clk);
      bus.request_valid_in = 1'b1;
      bus.vector_in        = 32'h0000_0000;
      bus.start_index_in   = 32'd0;
      @(posedge clk);
      #1;
      bus.request_valid_in = 1'b0;
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("arst_ready", 32'(bus.request_ready_out), 32'd1);
      check("arst_valid", 32'(bus.result_valid_out), 32'd0);
      check("arst_idx", bus.first_one_index_out, 32'd0);
      check("arst_found", 32'(bus.one_is_found_out), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      run_req("post_rst", 32'h0000_0100, 32'd0, 2, 1'b1, 32'd8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
